cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
- REQ-001: clk  input  1  single clock; all state updates on the rising edge.
- REQ-002: reset  input  1  asynchronous, active-low reset.
- REQ-003: Cond  input  4  instruction condition code.
- REQ-004: ALUFlags  input  4  ALU flags {C,Z,N,V}, bits [3:0].
- REQ-005: FlagW  input  2  flag write request; [1] selects the N,Z group, [0] selects the C,V group.
- REQ-006: PCS, RegW, MemW  input  1 each  unconditioned writes from the decoder.
- REQ-007: Stall  input  1  freezes all state for the cycle.
- REQ-008: PCSrc, RegWrite, MemWrite  output  1 each  condition-gated writes.
- REQ-009: Flags  output  4  current flag register {C,Z,N,V}.
- REQ-010: FlagPush, FlagPop  input  1 each; StackFull, StackEmpty, StackErr  output  1 each; present only under COND_FLAG_STACK_EN.

Function
- REQ-011: CondEx SHALL be combinational from Cond and the flag register, per code:
  - 0 EQ Z, 1 NE ~Z, 2 CS C, 3 CC ~C
  - 4 MI N, 5 PL ~N, 6 VS V, 7 VC ~V
  - 8 HI C&~Z, 9 LS ~C|Z
  - A GE N==V, B LT N!=V
  - C GT ~Z&(N==V), D LE Z|(N!=V)
  - E AL 1, F NV 0.
- REQ-012: PCSrc, RegWrite and MemWrite SHALL equal PCS, RegW and MemW respectively ANDed with CondEx and ~Stall, with zero latency.
- REQ-013: The N,Z group SHALL load ALUFlags[2:1] on the clock edge when FlagW[1], CondEx and ~Stall are all true.
- REQ-014: The C,V group SHALL load ALUFlags[3] and ALUFlags[0] on the clock edge when FlagW[0], CondEx and ~Stall are all true.
- REQ-015: Each flag group SHALL otherwise hold its value.
- REQ-016: Flag write latency SHALL be 1 cycle; the next instruction's CondEx SHALL see the updated flags.
- REQ-017: CondEx SHALL use the pre-update flags for the same cycle; there is no combinational bypass.
- REQ-018: ALUFlags bits that are X SHALL NOT be loaded when the corresponding FlagW bit is 0.

Reset
- REQ-019: While reset is low, the flag register SHALL be 4'b0000 immediately, independent of clk.
- REQ-020: The outputs SHALL follow from the reset flag state (Z=0, so EQ evaluates false and AL true).
- REQ-021: When COND_FLAG_STACK_EN is defined, reset SHALL also clear the stack, StackErr=0, StackEmpty=1, StackFull=0.
- REQ-022: A reset asserted during a flag write or push SHALL discard that operation.

Configuration
- REQ-023: With COND_FLAG_STACK_EN defined, a 2-entry flag save stack SHALL exist with a 2-bit occupancy counter (values 0..2).
- REQ-024: FlagPush SHALL save the pre-update flag register; a concurrent FlagW update SHALL still occur.
- REQ-025: FlagPop SHALL restore the flag register from the top entry and SHALL override any concurrent FlagW update.
- REQ-026: Push and pop asserted in the same cycle SHALL be a stack no-op.
- REQ-027: Push when full, or pop when empty, SHALL be ignored and SHALL set StackErr; StackErr is sticky until reset.
- REQ-028: Stall SHALL block push and pop.
- REQ-029: StackFull SHALL be registered-derived: occupancy == 2.
- REQ-030: StackEmpty SHALL be registered-derived: occupancy == 0.
- REQ-031: Without COND_FLAG_STACK_EN, the stack ports and logic SHALL be absent and behaviour SHALL be per REQ-011..018 only.

Structure
- REQ-032: Package cond_pkg SHALL hold the cond_e enum (EQ..NV) and the flag bit-index localparams (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0).
- REQ-033: Sub-module cond_eval SHALL be purely combinational, taking Cond and Flags and producing CondEx.
- REQ-034: cond_unit SHALL contain the flag register, the write gating and the optional stack.

Verification
- REQ-035: Release reset, then Cond=E with PCS=RegW=MemW=1 -> all three outputs 1, Flags=0000.
- REQ-036: Cond=E, FlagW=11, ALUFlags=0100 (Z) -> next cycle Flags=0100, EQ true, NE false.
- REQ-037: Flags=0100, then FlagW=01 with ALUFlags=1001 -> Flags=1101; N,Z unchanged at Z=1, N=0.
- REQ-038: Flags=0000, Cond=0 (EQ), FlagW=11, ALUFlags=0100 -> no flag update and RegWrite=0.
- REQ-039: Sweep all 16 Cond values against all 16 flag values -> CondEx matches the REQ-011 table; Stall=1 forces outputs 0 with Flags held.
- REQ-040: Stack enabled: push at Flags=0010, write Flags=1000, pop -> Flags=0010; a third push after two pushes -> StackErr=1 and StackFull=1.

Source files
------------

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and flag bit positions for cond_unit
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } cond_e;

   // Flag register layout is {C,Z,N,V}
   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic c, z, n, v;

   assign c = Flags[FLAG_C];
   assign z = Flags[FLAG_Z];
   assign n = Flags[FLAG_N];
   assign v = Flags[FLAG_V];

   // Decode the condition code against the current flags
   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         EQ: CondEx = z;
         NE: CondEx = ~z;
         CS: CondEx = c;
         CC: CondEx = ~c;
         MI: CondEx = n;
         PL: CondEx = ~n;
         VS: CondEx = v;
         VC: CondEx = ~v;
         HI: CondEx = c & ~z;
         LS: CondEx = ~c | z;
         GE: CondEx = (n == v);
         LT: CondEx = (n != v);
         GT: CondEx = ~z & (n == v);
         LE: CondEx = z | (n != v);
         AL: CondEx = 1'b1;
         NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register, condition-gated writes, optional flag stack (COND_FLAG_STACK_EN)
module cond_unit
   import cond_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       Stall,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
`ifdef COND_FLAG_STACK_EN
   input  logic       FlagPush,
   input  logic       FlagPop,
   output logic       StackFull,
   output logic       StackEmpty,
   output logic       StackErr,
`endif
   output logic [3:0] Flags
);

   logic [3:0] flags_q;
   logic       cond_ex;
   logic       go;
   logic       wr_nz;
   logic       wr_cv;

   cond_eval u_eval (
      .Cond   (Cond),
      .Flags  (flags_q),
      .CondEx (cond_ex)
   );

   // CondEx sees only the registered flags, so a same-cycle update never bypasses
   assign go       = cond_ex & ~Stall;
   assign PCSrc    = PCS  & go;
   assign RegWrite = RegW & go;
   assign MemWrite = MemW & go;
   assign wr_nz    = FlagW[1] & go;
   assign wr_cv    = FlagW[0] & go;
   assign Flags    = flags_q;

`ifdef COND_FLAG_STACK_EN
   logic [3:0] stk [2];
   logic [1:0] occ;
   logic       err;
   logic       do_push;
   logic       do_pop;
   logic       push_ok;
   logic       pop_ok;

   // Simultaneous push and pop cancel out; stall blocks both
   assign do_push = FlagPush & ~FlagPop & ~Stall;
   assign do_pop  = FlagPop & ~FlagPush & ~Stall;
   assign push_ok = do_push & (occ != 2'd2);
   assign pop_ok  = do_pop  & (occ != 2'd0);

   assign StackFull  = (occ == 2'd2);
   assign StackEmpty = (occ == 2'd0);
   assign StackErr   = err;

   // Stack storage, occupancy and sticky error; push slot is occ[0], top slot is occ[1]
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stk[0] <= 4'b0000;
         stk[1] <= 4'b0000;
         occ    <= 2'd0;
         err    <= 1'b0;
      end else begin
         if (push_ok) begin
            stk[occ[0]] <= flags_q;
            occ         <= occ + 2'd1;
         end else if (pop_ok) begin
            occ <= occ - 2'd1;
         end
         if ((do_push && occ == 2'd2) || (do_pop && occ == 2'd0))
            err <= 1'b1;
      end
   end
`endif

   // Flag register: per-group load enables; a successful pop wins over FlagW
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= 4'b0000;
      end else begin
`ifdef COND_FLAG_STACK_EN
         if (pop_ok) begin
            flags_q <= stk[occ[1]];
         end else begin
`endif
            if (wr_nz) begin
               flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
               flags_q[FLAG_N] <= ALUFlags[FLAG_N];
            end
            if (wr_cv) begin
               flags_q[FLAG_C] <= ALUFlags[FLAG_C];
               flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
`ifdef COND_FLAG_STACK_EN
         end
`endif
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - directed-vector bench for cond_unit
module tb_cond_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, Stall;
   logic       PCSrc, RegWrite, MemWrite;
   logic [3:0] Flags;
`ifdef COND_FLAG_STACK_EN
   logic       FlagPush, FlagPop;
   logic       StackFull, StackEmpty, StackErr;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Truth table per condition code, bit f set when the code passes at Flags=f ({C,Z,N,V})
   logic [15:0] masks [16];

   cond_unit dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .Stall      (Stall),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
`ifdef COND_FLAG_STACK_EN
      .FlagPush   (FlagPush),
      .FlagPop    (FlagPop),
      .StackFull  (StackFull),
      .StackEmpty (StackEmpty),
      .StackErr   (StackErr),
`endif
      .Flags      (Flags)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0;
`ifdef COND_FLAG_STACK_EN
      FlagPush = 1'b0; FlagPop = 1'b0;
`endif
   endtask

   task automatic load_flags(input logic [3:0] f);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = f; Stall = 1'b0;
      tick();
      FlagW = 2'b00;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #1;
      vectors++;
      if (Flags !== 4'b0000) begin
         $display("FAIL reset_async_clear: Flags=%b expected 0000", Flags); miscompares++;
      end
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111;
      tick();
      vectors++;
      if (Flags !== 4'b0000) begin
         $display("FAIL reset_discards_write: Flags=%b expected 0000", Flags); miscompares++;
      end
      FlagW = 2'b00; RegW = 1'b1; Cond = 4'h0;
      #1;
      vectors++;
      if (RegWrite !== 1'b0) begin
         $display("FAIL reset_eq_false: RegWrite=%b expected 0", RegWrite); miscompares++;
      end
      Cond = 4'hE;
      #1;
      vectors++;
      if (RegWrite !== 1'b1) begin
         $display("FAIL reset_al_true: RegWrite=%b expected 1", RegWrite); miscompares++;
      end
      reset = 1'b1;
      idle();
      tick();
   endtask

   task automatic test_always();
      idle();
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      #1;
      vectors++;
      if ({PCSrc, RegWrite, MemWrite, Flags} !== 7'b111_0000) begin
         $display("FAIL always_outputs: got %b %b %b flags %b expected 1 1 1 flags 0000",
                  PCSrc, RegWrite, MemWrite, Flags); miscompares++;
      end
      idle();
   endtask

   task automatic test_flag_write();
      idle();
      load_flags(4'b0100);
      vectors++;
      if (Flags !== 4'b0100) begin
         $display("FAIL write_nzcv: Flags=%b expected 0100", Flags); miscompares++;
      end
      RegW = 1'b1; Cond = 4'h0;
      #1;
      vectors++;
      if (RegWrite !== 1'b1) begin
         $display("FAIL eq_after_write: RegWrite=%b expected 1", RegWrite); miscompares++;
      end
      Cond = 4'h1;
      #1;
      vectors++;
      if (RegWrite !== 1'b0) begin
         $display("FAIL ne_after_write: RegWrite=%b expected 0", RegWrite); miscompares++;
      end
      Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b1001;
      tick();
      vectors++;
      if (Flags !== 4'b1101) begin
         $display("FAIL write_cv_only: Flags=%b expected 1101", Flags); miscompares++;
      end
      FlagW = 2'b01; ALUFlags = 4'b0xx0;
      tick();
      vectors++;
      if (Flags !== 4'b0100) begin
         $display("FAIL x_bits_not_loaded: Flags=%b expected 0100", Flags); miscompares++;
      end
      idle();
   endtask

   task automatic test_cond_fail();
      idle();
      load_flags(4'b0000);
      Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
      #1;
      vectors++;
      if (RegWrite !== 1'b0) begin
         $display("FAIL cond_fail_regwrite: RegWrite=%b expected 0", RegWrite); miscompares++;
      end
      tick();
      vectors++;
      if (Flags !== 4'b0000) begin
         $display("FAIL cond_fail_flags: Flags=%b expected 0000", Flags); miscompares++;
      end
      idle();
   endtask

   task automatic test_no_bypass();
      idle();
      load_flags(4'b0000);
      Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
      #1;
      vectors++;
      if (RegWrite !== 1'b1) begin
         $display("FAIL no_bypass_pre: RegWrite=%b expected 1", RegWrite); miscompares++;
      end
      tick();
      vectors++;
      if ({Flags, RegWrite} !== 5'b0100_0) begin
         $display("FAIL no_bypass_post: Flags=%b RegWrite=%b expected 0100 0", Flags, RegWrite);
         miscompares++;
      end
      idle();
   endtask

   task automatic test_sweep();
      idle();
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         vectors++;
         if (Flags !== 4'(f)) begin
            $display("FAIL sweep_load: Flags=%b expected %b", Flags, 4'(f)); miscompares++;
         end
         PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
         for (int c = 0; c < 16; c++) begin
            logic e;
            Cond = 4'(c);
            #1;
            e = masks[c][f];
            vectors++;
            if ({PCSrc, RegWrite, MemWrite} !== {3{e}}) begin
               $display("FAIL sweep_cond%0h_flags%b: got %b%b%b expected %b%b%b",
                        c, 4'(f), PCSrc, RegWrite, MemWrite, e, e, e);
               miscompares++;
            end
         end
         PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
      end
      idle();
   endtask

   task automatic test_stall();
      idle();
      load_flags(4'b1111);
      Stall = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0000;
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      #1;
      vectors++;
      if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
         $display("FAIL stall_outputs: got %b%b%b expected 000", PCSrc, RegWrite, MemWrite);
         miscompares++;
      end
      tick();
      vectors++;
      if (Flags !== 4'b1111) begin
         $display("FAIL stall_hold: Flags=%b expected 1111", Flags); miscompares++;
      end
      idle();
   endtask

   task automatic test_back_to_back();
      idle();
      load_flags(4'b0000);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
      tick();
      vectors++;
      if (Flags !== 4'b0100) begin
         $display("FAIL b2b_first: Flags=%b expected 0100", Flags); miscompares++;
      end
      Cond = 4'h0; FlagW = 2'b01; ALUFlags = 4'b1001;
      tick();
      vectors++;
      if (Flags !== 4'b1101) begin
         $display("FAIL b2b_second: Flags=%b expected 1101", Flags); miscompares++;
      end
      Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      vectors++;
      if (Flags !== 4'b1101) begin
         $display("FAIL b2b_third_blocked: Flags=%b expected 1101", Flags); miscompares++;
      end
      idle();
   endtask

`ifdef COND_FLAG_STACK_EN
   task automatic test_stack();
      idle();
      reset = 1'b0; #1; reset = 1'b1;
      vectors++;
      if ({StackEmpty, StackFull, StackErr} !== 3'b100) begin
         $display("FAIL stack_reset: E/F/Err=%b%b%b expected 100", StackEmpty, StackFull, StackErr);
         miscompares++;
      end
      load_flags(4'b0010);
      FlagPush = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1000;
      tick();
      FlagPush = 1'b0; FlagW = 2'b00;
      vectors++;
      if ({Flags, StackEmpty} !== 5'b1000_0) begin
         $display("FAIL stack_push_write: Flags=%b Empty=%b expected 1000 0", Flags, StackEmpty);
         miscompares++;
      end
      FlagPop = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
      tick();
      FlagPop = 1'b0; FlagW = 2'b00;
      vectors++;
      if ({Flags, StackEmpty} !== 5'b0010_1) begin
         $display("FAIL stack_pop_restore: Flags=%b Empty=%b expected 0010 1", Flags, StackEmpty);
         miscompares++;
      end
      Stall = 1'b1; FlagPush = 1'b1;
      tick();
      Stall = 1'b0;
      vectors++;
      if (StackEmpty !== 1'b1) begin
         $display("FAIL stack_stall_push: Empty=%b expected 1", StackEmpty); miscompares++;
      end
      tick();
      tick();
      vectors++;
      if ({StackFull, StackErr} !== 2'b10) begin
         $display("FAIL stack_two_push: Full/Err=%b%b expected 10", StackFull, StackErr);
         miscompares++;
      end
      tick();
      FlagPush = 1'b0;
      vectors++;
      if ({StackFull, StackErr} !== 2'b11) begin
         $display("FAIL stack_overflow: Full/Err=%b%b expected 11", StackFull, StackErr);
         miscompares++;
      end
      FlagPush = 1'b1; FlagPop = 1'b1;
      tick();
      FlagPush = 1'b0;
      vectors++;
      if (StackFull !== 1'b1) begin
         $display("FAIL stack_push_pop_noop: Full=%b expected 1", StackFull); miscompares++;
      end
      tick();
      FlagPop = 1'b0;
      vectors++;
      if ({Flags, StackFull, StackEmpty} !== 6'b0010_00) begin
         $display("FAIL stack_pop_one: Flags=%b F/E=%b%b expected 0010 00", Flags, StackFull, StackEmpty);
         miscompares++;
      end
      reset = 1'b0; #1; reset = 1'b1;
      vectors++;
      if ({StackEmpty, StackErr} !== 2'b10) begin
         $display("FAIL stack_err_cleared: E/Err=%b%b expected 10", StackEmpty, StackErr);
         miscompares++;
      end
      FlagPop = 1'b1;
      tick();
      FlagPop = 1'b0;
      vectors++;
      if ({Flags, StackEmpty, StackErr} !== 6'b0000_11) begin
         $display("FAIL stack_underflow: Flags=%b E/Err=%b%b expected 0000 11", Flags, StackEmpty, StackErr);
         miscompares++;
      end
      idle();
   endtask
`endif

   initial begin
      masks[0]  = 16'hF0F0; masks[1]  = 16'h0F0F;
      masks[2]  = 16'hFF00; masks[3]  = 16'h00FF;
      masks[4]  = 16'hCCCC; masks[5]  = 16'h3333;
      masks[6]  = 16'hAAAA; masks[7]  = 16'h5555;
      masks[8]  = 16'h0F00; masks[9]  = 16'hF0FF;
      masks[10] = 16'h9999; masks[11] = 16'h6666;
      masks[12] = 16'h0909; masks[13] = 16'hF6F6;
      masks[14] = 16'hFFFF; masks[15] = 16'h0000;
      reset = 1'b1;
      test_reset();
      test_always();
      test_flag_write();
      test_cond_fail();
      test_no_bypass();
      test_sweep();
      test_stall();
      test_back_to_back();
`ifdef COND_FLAG_STACK_EN
      test_stack();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
